iiitb_rv32i_mem_arbiter: RTL and testbench

- Shares the single-port unified instruction/data memory of the rv32i core between three requesters: boot loader, load/store (data) port and instruction fetch.
- Sequences a LOAD phase, where only the loader owns memory and the core is stalled, and a RUN phase, where data and fetch compete under data-first priority with a fetch anti-starvation counter.
- Sits between the core and the memory array; the memory has a registered read with 1-cycle latency.

---
 rtl/iiitb_rv32i_mem_arbiter_if.sv | 61 ++++++
 rtl/iiitb_rv32i_mem_arbiter.sv | 103 ++++++++++
 tb/tb_iiitb_rv32i_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/iiitb_rv32i_mem_arbiter_if.sv
// Bundle of requester, core and memory-side signals around the unified memory arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding core/memory view.
interface iiitb_rv32i_mem_arbiter_if #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) ();
  logic          load_active;
  // Loader port
  logic          l_req;
  logic          l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          l_gnt;
  // Data (load/store) port
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  // Instruction fetch port
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  // Shared return data and pipeline stall
  logic [DW-1:0] rdata;
  logic          core_stall;
  // Memory array side
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  load_active,
    input  l_req, l_we, l_addr, l_wdata,
    output l_gnt,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid,
    input  f_req, f_addr,
    output f_gnt, f_rvalid,
    output rdata, core_stall,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output load_active,
    output l_req, l_we, l_addr, l_wdata,
    input  l_gnt,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid,
    output f_req, f_addr,
    input  f_gnt, f_rvalid,
    input  rdata, core_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/iiitb_rv32i_mem_arbiter.sv
// Single-port unified memory arbiter for the rv32i core.
// LOAD: boot loader owns memory, core stalled. RUN: data beats fetch unless fetch has been
// starved for STARVE_LIMIT consecutive cycles.
module iiitb_rv32i_mem_arbiter #(
  parameter int unsigned AW           = 10,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                          clk,
  input logic                          rst_n,
  iiitb_rv32i_mem_arbiter_if.slave     bus
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  typedef enum logic [0:0] {StLoad, StRun} state_e;

  state_e        state_q, state_d;
  logic [3:0]    starve_q, starve_d;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          d_rvalid_q, f_rvalid_q;
  logic          l_gnt, d_gnt, f_gnt;
  logic          fetch_first;

  // Mode follows load_active with one edge of delay.
  always_comb begin
    state_d = bus.load_active ? StLoad : StRun;
  end

  // Arbitration on the current mode; grants are same-cycle and mutually exclusive.
  always_comb begin
    l_gnt       = 1'b0;
    d_gnt       = 1'b0;
    f_gnt       = 1'b0;
    fetch_first = bus.f_req && (starve_q == Limit);
    case (state_q)
      StLoad: l_gnt = bus.l_req;
      StRun: begin
        if (fetch_first)    f_gnt = 1'b1;
        else if (bus.d_req) d_gnt = 1'b1;
        else if (bus.f_req) f_gnt = 1'b1;
      end
      default: ;
    endcase
  end

  // Fetch starvation counter: counts fetch losses to data, cleared whenever fetch is idle,
  // granted, or the arbiter is (or is entering) LOAD.
  always_comb begin
    starve_d = starve_q;
    if (bus.load_active || (state_q == StLoad) || !bus.f_req || f_gnt) begin
      starve_d = '0;
    end else if (d_gnt && (starve_q != Limit)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Outputs: memory command from the granted port, otherwise the held shadow address/data.
  always_comb begin
    bus.l_gnt      = l_gnt;
    bus.d_gnt      = d_gnt;
    bus.f_gnt      = f_gnt;
    bus.core_stall = (state_q == StLoad) | (bus.d_req & ~d_gnt) | (bus.f_req & ~f_gnt);
    bus.mem_en     = l_gnt | d_gnt | f_gnt;
    bus.mem_we     = (l_gnt & bus.l_we) | (d_gnt & bus.d_we);
    bus.mem_addr   = addr_q;
    bus.mem_wdata  = wdata_q;
    if (l_gnt) begin
      bus.mem_addr  = bus.l_addr;
      bus.mem_wdata = bus.l_wdata;
    end else if (d_gnt) begin
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end else if (f_gnt) begin
      // Fetch is read-only, write data keeps its previous value.
      bus.mem_addr  = bus.f_addr;
    end
    bus.rdata    = bus.mem_rdata;
    bus.d_rvalid = d_rvalid_q;
    bus.f_rvalid = f_rvalid_q;
  end

  // State, counter, address/data shadows and read-return flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StLoad;
      starve_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      d_rvalid_q <= 1'b0;
      f_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      addr_q     <= bus.mem_addr;
      wdata_q    <= bus.mem_wdata;
      d_rvalid_q <= d_gnt & ~bus.d_we;
      f_rvalid_q <= f_gnt;
    end
  end

endmodule

// File: tb/tb_iiitb_rv32i_mem_arbiter.sv
// Self-checking bench for iiitb_rv32i_mem_arbiter: directed stimulus, a transaction-level
// reference model compared every cycle, and literal expectations for the headline scenarios.
module tb_iiitb_rv32i_mem_arbiter;
  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned LIMIT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iiitb_rv32i_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  iiitb_rv32i_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory array: registered read, 1-cycle latency; preloaded with a recognisable pattern.
  logic [DW-1:0] mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA5A50000 | 32'(i);
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (bus.mem_en) begin
        if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
        else            bus.mem_rdata <= mem[bus.mem_addr];
      end
    end
  end

  // Reference model state (committed on the clock edge, cleared by reset).
  logic          m_loading;
  int            m_streak;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_dp, m_fp;
  logic [DW-1:0] m_ret;
  // Values the model intends to commit at the next edge.
  logic          n_loading = 1'b1;
  int            n_streak  = 0;
  logic [AW-1:0] n_addr    = '0;
  logic [DW-1:0] n_wdata   = '0;
  logic          n_dp      = 1'b0;
  logic          n_fp      = 1'b0;
  logic [DW-1:0] n_ret     = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loading <= 1'b1;
      m_streak  <= 0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_dp      <= 1'b0;
      m_fp      <= 1'b0;
      m_ret     <= '0;
    end else begin
      m_loading <= n_loading;
      m_streak  <= n_streak;
      m_addr    <= n_addr;
      m_wdata   <= n_wdata;
      m_dp      <= n_dp;
      m_fp      <= n_fp;
      m_ret     <= n_ret;
    end
  end

  // Compare process: predict every output from the rules, check, and plan the next state.
  logic [DW-1:0] gold [1024];
  initial begin
    logic          e_l, e_d, e_f, e_stall, e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    for (int i = 0; i < 1024; i++) gold[i] = 32'hA5A50000 | 32'(i);
    forever begin
      @(negedge clk);
      e_l = 1'b0; e_d = 1'b0; e_f = 1'b0;
      if (m_loading)                                  e_l = bus.l_req;
      else if (bus.f_req && m_streak == int'(LIMIT))  e_f = 1'b1;
      else if (bus.d_req)                             e_d = 1'b1;
      else if (bus.f_req)                             e_f = 1'b1;
      e_stall = m_loading || (bus.d_req && !e_d) || (bus.f_req && !e_f);
      e_en    = e_l || e_d || e_f;
      e_we    = (e_l && bus.l_we) || (e_d && bus.d_we);
      e_addr  = e_l ? bus.l_addr  : e_d ? bus.d_addr  : e_f ? bus.f_addr : m_addr;
      e_wdata = e_l ? bus.l_wdata : e_d ? bus.d_wdata : m_wdata;

      check("cyc l_gnt",      bus.l_gnt,      e_l);
      check("cyc d_gnt",      bus.d_gnt,      e_d);
      check("cyc f_gnt",      bus.f_gnt,      e_f);
      check("cyc core_stall", bus.core_stall, e_stall);
      check("cyc mem_en",     bus.mem_en,     e_en);
      check("cyc mem_we",     bus.mem_we,     e_we);
      check("cyc mem_addr",   bus.mem_addr,   e_addr);
      check("cyc mem_wdata",  bus.mem_wdata,  e_wdata);
      check("cyc d_rvalid",   bus.d_rvalid,   m_dp);
      check("cyc f_rvalid",   bus.f_rvalid,   m_fp);
      if (m_dp || m_fp) check("cyc rdata", bus.rdata, m_ret);

      n_loading = bus.load_active;
      if (bus.load_active || m_loading || !bus.f_req || e_f) n_streak = 0;
      else n_streak = (m_streak < int'(LIMIT)) ? m_streak + 1 : int'(LIMIT);
      n_addr  = e_addr;
      n_wdata = e_wdata;
      n_dp    = e_d && !bus.d_we;
      n_fp    = e_f;
      n_ret   = gold[e_addr];
      if (e_we) gold[e_addr] = e_wdata;
    end
  end

  task automatic idle();
    bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = '0; bus.l_wdata = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.f_req = 1'b0; bus.f_addr = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    logic [14:0] fpat;
    logic        saw_rv;
    idle();
    bus.load_active = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset core_stall", bus.core_stall, 1'b1);
    check("reset mem_addr",   bus.mem_addr,   '0);
    check("reset f_rvalid",   bus.f_rvalid,   1'b0);
    next_cycle();
    rst_n = 1'b1;

    // 1: loader writes, data/fetch requests ignored while loading
    next_cycle();
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 10'd0; bus.l_wdata = 32'h00208300;
    @(negedge clk);
    check("t1 l_gnt0",  bus.l_gnt,      1'b1);
    check("t1 we0",     bus.mem_we,     1'b1);
    check("t1 stall0",  bus.core_stall, 1'b1);
    next_cycle();
    bus.l_addr = 10'd1; bus.l_wdata = 32'h00209380;
    bus.d_req = 1'b1; bus.f_req = 1'b1;
    @(negedge clk);
    check("t1 l_gnt1",  bus.l_gnt, 1'b1);
    check("t1 d_gnt1",  bus.d_gnt, 1'b0);
    check("t1 f_gnt1",  bus.f_gnt, 1'b0);
    next_cycle();
    idle();
    bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 10'd0;
    @(negedge clk);
    check("t1 lrd mem_en", bus.mem_en, 1'b1);
    check("t1 lrd mem_we", bus.mem_we, 1'b0);
    next_cycle();
    idle();
    @(negedge clk);
    check("t1 lrd no f_rvalid", bus.f_rvalid, 1'b0);
    check("t1 lrd no d_rvalid", bus.d_rvalid, 1'b0);

    // 2: leave LOAD and fetch addr 0
    next_cycle();
    bus.load_active = 1'b0;
    @(negedge clk);
    check("t2 still LOAD stall", bus.core_stall, 1'b1);
    next_cycle();
    bus.f_req = 1'b1; bus.f_addr = 10'd0;
    @(negedge clk);
    check("t2 f_gnt", bus.f_gnt, 1'b1);
    check("t2 stall", bus.core_stall, 1'b0);
    next_cycle();
    idle();
    @(negedge clk);
    check("t2 f_rvalid", bus.f_rvalid, 1'b1);
    check("t2 rdata",    bus.rdata,    32'h00208300);

    // 3: data beats fetch, fetch next cycle
    next_cycle();
    bus.d_req = 1'b1; bus.d_addr = 10'd9; bus.f_req = 1'b1; bus.f_addr = 10'd2;
    @(negedge clk);
    check("t3 d_gnt", bus.d_gnt, 1'b1);
    check("t3 f_gnt", bus.f_gnt, 1'b0);
    check("t3 stall", bus.core_stall, 1'b1);
    next_cycle();
    bus.d_req = 1'b0;
    @(negedge clk);
    check("t3 f_gnt2",   bus.f_gnt,    1'b1);
    check("t3 d_rvalid", bus.d_rvalid, 1'b1);
    check("t3 rdata9",   bus.rdata,    32'hA5A50009);
    next_cycle();
    idle();
    @(negedge clk);
    check("t3 f_rvalid", bus.f_rvalid, 1'b1);
    check("t3 rdata2",   bus.rdata,    32'hA5A50002);

    // 4: sustained contention -> D,D,D,D,F repeating
    next_cycle();
    bus.d_req = 1'b1; bus.d_addr = 10'd5; bus.f_req = 1'b1; bus.f_addr = 10'd6;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      fpat[i] = bus.f_gnt;
      if (i < 14) next_cycle();
    end
    check("t4 grant pattern", {49'd0, fpat}, {49'd0, 15'b100001000010000});
    next_cycle();
    idle();

    // 5: store then load
    next_cycle();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 10'd3; bus.d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("t5 st d_gnt",  bus.d_gnt,  1'b1);
    check("t5 st mem_we", bus.mem_we, 1'b1);
    next_cycle();
    bus.d_we = 1'b0; bus.d_wdata = '0;
    @(negedge clk);
    check("t5 st no rvalid", bus.d_rvalid, 1'b0);
    next_cycle();
    idle();
    @(negedge clk);
    check("t5 ld rvalid", bus.d_rvalid, 1'b1);
    check("t5 ld rdata",  bus.rdata,    32'hDEADBEEF);

    // 6: reset right after a fetch grant drops the return
    next_cycle();
    bus.f_req = 1'b1; bus.f_addr = 10'd1;
    @(negedge clk);
    check("t6 f_gnt", bus.f_gnt, 1'b1);
    #2;
    rst_n = 1'b0;
    idle();
    bus.load_active = 1'b1;
    #1;
    check("t6 rst stall",     bus.core_stall, 1'b1);
    check("t6 rst mem_addr",  bus.mem_addr,   '0);
    check("t6 rst mem_wdata", bus.mem_wdata,  '0);
    check("t6 rst f_gnt",     bus.f_gnt,      1'b0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    saw_rv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      saw_rv = saw_rv | bus.f_rvalid | bus.d_rvalid;
      next_cycle();
    end
    check("t6 no rvalid after reset", saw_rv, 1'b0);
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 10'd7; bus.l_wdata = 32'h12345678;
    @(negedge clk);
    check("t6 state LOAD l_gnt", bus.l_gnt, 1'b1);
    next_cycle();
    idle();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
